// File: rtl/alu_iter_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for alu_iter.
package alu_iter_pkg;

    localparam int OP_AND   = 0;
    localparam int OP_OR    = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SLTU  = 3;
    localparam int OP_SUB   = 6;
    localparam int OP_SLT   = 7;
    localparam int OP_MULTU = 8;
    localparam int OP_MULT  = 9;
    localparam int OP_DIVU  = 10;
    localparam int OP_DIV   = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Multiply/divide opcodes are exactly 10xx; everything else is single-cycle.
    function automatic logic is_long_op(input logic [31:0] op);
        return op[31:2] == 30'd2;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// W-cycle shift-add multiplier / restoring divider on operand magnitudes,
// with a combinational sign-fix on the final iteration so the result is
// ready in the same cycle that done pulses.
module alu_iter_muldiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi
);
    localparam int CW = $clog2(W + 1);

    logic            busy_reg;
    logic            div_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic [CW-1:0]   count_reg;
    logic [W-1:0]    hi_reg;
    logic [W-1:0]    lo_reg;
    logic [W-1:0]    opd_reg;

    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W:0]      add_sum;
    logic [W:0]      shifted;
    logic [W:0]      trial;
    logic [W-1:0]    hi_next;
    logic [W-1:0]    lo_next;
    logic [2*W-1:0]  prod_fix;

    // Two's-complement MIN maps onto 2^(W-1), which is its correct magnitude.
    assign a_neg = is_signed && a[W-1];
    assign b_neg = is_signed && b[W-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign done  = busy_reg && (count_reg == CW'(W - 1));

    // One iteration: hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : '0);
        shifted = {hi_reg, lo_reg[W-1]};
        trial   = shifted - {1'b0, opd_reg};
        if (div_reg) begin
            if (!trial[W]) begin
                hi_next = trial[W-1:0];
                lo_next = {lo_reg[W-2:0], 1'b1};
            end else begin
                hi_next = shifted[W-1:0];
                lo_next = {lo_reg[W-2:0], 1'b0};
            end
        end else begin
            hi_next = add_sum[W:1];
            lo_next = {add_sum[0], lo_reg[W-1:1]};
        end
    end

    // Sign fix: product negated as a 2W value, quotient/remainder negated independently.
    always_comb begin
        prod_fix = neg_q_reg ? -{hi_next, lo_next} : {hi_next, lo_next};
        if (div_reg) begin
            res_lo = neg_q_reg ? -lo_next : lo_next;
            res_hi = neg_r_reg ? -hi_next : hi_next;
        end else begin
            res_lo = prod_fix[W-1:0];
            res_hi = prod_fix[2*W-1:W];
        end
    end

    // Load magnitudes on start, then iterate once per cycle for W cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_reg  <= 1'b0;
            div_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            opd_reg   <= '0;
        end else if (start) begin
            busy_reg  <= 1'b1;
            div_reg   <= is_div;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= is_div ? a_mag : b_mag;
            opd_reg   <= is_div ? b_mag : a_mag;
        end else if (busy_reg) begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            if (done) begin
                busy_reg  <= 1'b0;
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle logic/arith/compare ops plus iterative
// mul/div through alu_iter_muldiv, with held registered results.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  overflow,
    output logic                  carry_out,
    output logic                  zero,
    output logic                  div_by_zero
);
    localparam int W = DATA_WIDTH;

    state_t        state_reg;
    state_t        state_next;
    logic [31:0]   op_w;
    logic          accept;
    logic          long_op;
    logic          div_op;
    logic          b_zero;
    logic          md_start;
    logic          md_done;
    logic [W-1:0]  md_lo;
    logic [W-1:0]  md_hi;
    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [W-1:0]  sc_lo;
    logic [W-1:0]  sc_hi;
    logic          sc_ov;
    logic          sc_c;
    logic          sc_dbz;
    logic          sc_legal;
    logic [W-1:0]  lo_reg;
    logic [W-1:0]  hi_reg;
    logic          ov_reg;
    logic          c_reg;
    logic          z_reg;
    logic          dbz_reg;

    assign op_w     = 32'(op);
    assign long_op  = is_long_op(op_w);
    assign div_op   = long_op && op_w[1];
    assign b_zero   = (b == '0);
    assign accept   = in_valid && (state_reg == S_IDLE);
    // Divide by zero never enters the iterative datapath.
    assign md_start = accept && long_op && !(div_op && b_zero);
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

    assign result_lo   = lo_reg;
    assign result_hi   = hi_reg;
    assign overflow    = ov_reg;
    assign carry_out   = c_reg;
    assign zero        = z_reg;
    assign div_by_zero = dbz_reg;

    // Single-cycle results (and the divide-by-zero shortcut) from the live inputs.
    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_ov    = 1'b0;
        sc_c     = 1'b0;
        sc_dbz   = 1'b0;
        sc_legal = 1'b1;
        case (op_w)
            OP_AND: sc_lo = a & b;
            OP_OR:  sc_lo = a | b;
            OP_ADD: begin
                sc_lo = sum[W-1:0];
                sc_c  = sum[W];
                sc_ov = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                sc_lo = diff[W-1:0];
                sc_c  = diff[W];
                sc_ov = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_SLTU: sc_lo = W'(a < b);
            OP_SLT:  sc_lo = W'($signed(a) < $signed(b));
            OP_MULTU, OP_MULT: begin
                sc_legal = 1'b1;
            end
            OP_DIVU, OP_DIV: begin
                if (b_zero) begin
                    sc_lo  = '1;
                    sc_hi  = a;
                    sc_dbz = 1'b1;
                end
            end
            default: sc_legal = 1'b0;
        endcase
    end

    // Control FSM: accept in IDLE, iterate in BUSY, hold result in DONE.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) state_next = md_start ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (md_done) state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    // Result registers: loaded once per op, untouched while DONE waits for out_ready.
    // Illegal opcodes leave every output, zero included, at 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lo_reg  <= '0;
            hi_reg  <= '0;
            ov_reg  <= 1'b0;
            c_reg   <= 1'b0;
            z_reg   <= 1'b0;
            dbz_reg <= 1'b0;
        end else if (accept && !md_start) begin
            lo_reg  <= sc_lo;
            hi_reg  <= sc_hi;
            ov_reg  <= sc_ov;
            c_reg   <= sc_c;
            z_reg   <= sc_legal && (sc_lo == '0);
            dbz_reg <= sc_dbz;
        end else if (md_done) begin
            lo_reg  <= md_lo;
            hi_reg  <= md_hi;
            ov_reg  <= 1'b0;
            c_reg   <= 1'b0;
            z_reg   <= (md_lo == '0);
            dbz_reg <= 1'b0;
        end
    end

    alu_iter_muldiv #(
        .W (W)
    ) u_muldiv (
        .clk       (clk),
        .resetn    (resetn),
        .start     (md_start),
        .is_div    (div_op),
        .is_signed (op_w[0]),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .res_lo    (md_lo),
        .res_hi    (md_hi)
    );

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: the driver pushes reference-model results,
// an independent monitor pops and compares whenever out_valid is presented.
module tb_alu_iter;
    import alu_iter_pkg::*;

    localparam int W   = 32;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           resetn = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [OPW-1:0] op = '0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   result_lo;
    logic [W-1:0]   result_hi;
    logic           overflow;
    logic           carry_out;
    logic           zero;
    logic           div_by_zero;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int stall_tag = 0;
    int stall_len = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         ov;
        logic         c;
        logic         z;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];

    alu_iter #(
        .DATA_WIDTH (W),
        .OP_WIDTH   (OPW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .overflow    (overflow),
        .carry_out   (carry_out),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: plain wide integer arithmetic on the opcode's meaning.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int acc);
        exp_t   e;
        longint sx, sy, sr, maxs, mins;
        logic [63:0] ux, uy, ur;
        e.op = o; e.a = x; e.b = y; e.acc = acc;
        e.lo = '0; e.hi = '0; e.ov = 1'b0; e.c = 1'b0; e.z = 1'b0; e.dbz = 1'b0; e.lat = 1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        maxs = (longint'(1) <<< (W - 1)) - 1;
        mins = -(longint'(1) <<< (W - 1));
        case (o)
            4'h0: e.lo = x & y;
            4'h1: e.lo = x | y;
            4'h2: begin
                ur = ux + uy; e.lo = W'(ur); e.c = ur[W];
                sr = sx + sy; e.ov = (sr > maxs) || (sr < mins);
            end
            4'h6: begin
                e.lo = x - y; e.c = (x >= y);
                sr = sx - sy; e.ov = (sr > maxs) || (sr < mins);
            end
            4'h3: e.lo = W'(x < y);
            4'h7: e.lo = W'(sx < sy);
            4'h8: begin
                ur = ux * uy; e.lo = W'(ur); e.hi = W'(ur >> W); e.lat = W + 1;
            end
            4'h9: begin
                sr = sx * sy; ur = 64'(sr); e.lo = W'(ur); e.hi = W'(ur >> W); e.lat = W + 1;
            end
            4'hA, 4'hB: begin
                if (y == '0) begin
                    e.lo = '1; e.hi = x; e.dbz = 1'b1;
                end else if (o == 4'hA) begin
                    e.lo = W'(ux / uy); e.hi = W'(ux % uy); e.lat = W + 1;
                end else begin
                    e.lo = W'(sx / sy); e.hi = W'(sx % sy); e.lat = W + 1;
                end
            end
            default: ;
        endcase
        if (o inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB})
            e.z = (e.lo == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return '1;
            3: return {1'b1, {(W-1){1'b0}}};
            4: return {1'b0, {(W-1){1'b1}}};
            5: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Drive one op, wait (bounded) for acceptance, push its expected result.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit push);
        int waited = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout op=%h in_ready=%b required 1", o, in_ready);
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back(model(o, x, y, cycle + 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({in_ready, out_valid, result_lo, result_hi, overflow, carry_out, zero, div_by_zero}
            !== {1'b1, 1'b0, {(2*W+4){1'b0}}}) begin
            failures++;
            $display("FAIL %s in_ready=%b out_valid=%b lo=%h hi=%h flags=%b%b%b%b required in_ready=1 rest 0",
                     name, in_ready, out_valid, result_lo, result_hi,
                     overflow, carry_out, zero, div_by_zero);
        end
    endtask

    // Monitor / scoreboard consumer; also owns out_ready.
    initial begin : monitor
        exp_t e;
        logic [2*W+3:0] got, req, held;
        bit presented;
        int seen_tag, stall_cnt, lat;
        presented = 1'b0; seen_tag = 0; stall_cnt = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                sb.delete();
                presented = 1'b0;
                stall_cnt = 0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                got = {result_lo, result_hi, overflow, carry_out, zero, div_by_zero};
                if (!presented) begin
                    presented = 1'b1;
                    held = got;
                    if (stall_tag != seen_tag) begin
                        seen_tag = stall_tag;
                        stall_cnt = stall_len;
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output lo=%h hi=%h required no output", result_lo, result_hi);
                    end else begin
                        e = sb.pop_front();
                        req = {e.lo, e.hi, e.ov, e.c, e.z, e.dbz};
                        lat = cycle - e.acc + 1;
                        $display("txn op=%h a=%h b=%h lo=%h hi=%h ov=%b c=%b z=%b dbz=%b lat=%0d",
                                 e.op, e.a, e.b, result_lo, result_hi, overflow, carry_out,
                                 zero, div_by_zero, lat);
                        if (got !== req) begin
                            failures++;
                            $display("FAIL result op=%h a=%h b=%h got lo=%h hi=%h ov/c/z/dbz=%b%b%b%b required lo=%h hi=%h ov/c/z/dbz=%b%b%b%b",
                                     e.op, e.a, e.b, result_lo, result_hi, overflow, carry_out,
                                     zero, div_by_zero, e.lo, e.hi, e.ov, e.c, e.z, e.dbz);
                        end
                        checks++;
                        if (lat != e.lat) begin
                            failures++;
                            $display("FAIL latency op=%h got %0d required %0d", e.op, lat, e.lat);
                        end
                    end
                end else begin
                    checks++;
                    if (got !== held || in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL hold_stable got=%h in_ready=%b required=%h in_ready=0",
                                 got, in_ready, held);
                    end
                end
                if (stall_cnt > 0) begin
                    out_ready = 1'b0;
                    stall_cnt--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready) presented = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 1) != 0);
            end
        end
    end

    // Stimulus: directed corner cases, backpressure, mid-BUSY reset, random sweep.
    initial begin : stimulus
        logic [3:0] legal_ops [10];
        logic [3:0] illegal_ops [6];
        logic [3:0] o;
        int waited;
        legal_ops   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
        illegal_ops = '{4'h4, 4'h5, 4'hC, 4'hD, 4'hE, 4'hF};

        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        resetn = 1'b1;

        issue(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        issue(4'h6, 32'h0000_0000, 32'h8000_0000, 1'b1);
        issue(4'h6, 32'h0000_0005, 32'h0000_0005, 1'b1);
        issue(4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        issue(4'h3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        issue(4'h9, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        issue(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(4'hB, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        issue(4'hB, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(4'hA, 32'h0000_0009, 32'h0000_0000, 1'b1);
        issue(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
        issue(4'h1, 32'h0000_0000, 32'h0000_0000, 1'b1);
        issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        stall_len = 5;
        stall_tag++;
        issue(4'hB, 32'h0000_0064, 32'hFFFF_FFF9, 1'b1);

        // Leave non-zero results in the output registers, then abort a MULT.
        issue(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(4'h9, 32'h0000_0123, 32'h0000_0456, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy_status in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        resetn = 1'b0;
        #1;
        check_reset_outputs("reset_mid_busy");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset in_ready=%b required 1", in_ready);
        end
        issue(4'h9, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) o = illegal_ops[$urandom_range(0, 5)];
            else                           o = legal_ops[$urandom_range(0, 9)];
            issue(o, pick(), pick(), 1'b1);
        end

        waited = 0;
        while ((sb.size() != 0 || out_valid) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog cycle=%0d required completion", cycle);
        $fatal(1, "simulation time limit reached");
    end

endmodule
